// File: rtl/rx_measure_ctrl.sv
// rtl/rx_measure_ctrl.sv - run controller for the rx frame error measurement
module rx_measure_ctrl #(
  parameter int CLR_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 125000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] target_frames,
  input  logic [31:0] det_count,
  input  logic [31:0] det_ok,
  input  logic [31:0] det_ng,
  output logic        det_rst,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic [31:0] res_count,
  output logic [31:0] res_ok,
  output logic [31:0] res_ng,
  output logic [31:0] elapsed,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ARM   = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4,
    S_TOERR = 3'd5
  } state_t;

  localparam logic [7:0]  CLR_LAST = 8'(CLR_CYCLES - 1);
  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        det_rst_q, det_rst_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        toerr_q, toerr_d;
  logic [31:0] res_count_q, res_count_d;
  logic [31:0] res_ok_q, res_ok_d;
  logic [31:0] res_ng_q, res_ng_d;
  logic [31:0] elapsed_q, elapsed_d;
  logic [31:0] tgt_q, tgt_d;
  logic [7:0]  clr_cnt_q, clr_cnt_d;
  logic [31:0] idle_cnt_q, idle_cnt_d;
  logic [31:0] cnt_prev_q;
  logic        wd_fire;

  // Next-state and result latching; abort beats completion beats watchdog.
  always_comb begin
    state_d     = state_q;
    done_d      = done_q;
    toerr_d     = toerr_q;
    res_count_d = res_count_q;
    res_ok_d    = res_ok_q;
    res_ng_d    = res_ng_q;
    elapsed_d   = elapsed_q;
    tgt_d       = tgt_q;
    clr_cnt_d   = clr_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    wd_fire     = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_TOERR: begin
        if (start) begin
          tgt_d       = (target_frames == 32'd0) ? 32'd1 : target_frames;
          done_d      = 1'b0;
          toerr_d     = 1'b0;
          res_count_d = 32'd0;
          res_ok_d    = 32'd0;
          res_ng_d    = 32'd0;
          elapsed_d   = 32'd0;
          clr_cnt_d   = 8'd0;
          state_d     = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (clr_cnt_q == CLR_LAST) begin
          idle_cnt_d = 32'd0;
          state_d    = S_ARM;
        end else begin
          clr_cnt_d = clr_cnt_q + 8'd1;
        end
      end
      S_ARM, S_RUN: begin
        if (abort) begin
          // results and elapsed are left as they were
          state_d = S_IDLE;
        end else begin
          elapsed_d = (elapsed_q == 32'hFFFF_FFFF) ? elapsed_q : elapsed_q + 32'd1;
          if (state_q == S_RUN && det_count >= tgt_q) begin
            res_count_d = det_count;
            res_ok_d    = det_ok;
            res_ng_d    = det_ng;
            done_d      = 1'b1;
            state_d     = S_DONE;
          end else begin
            if (det_count != cnt_prev_q) begin
              idle_cnt_d = 32'd0;
            end else if (idle_cnt_q == TO_LAST) begin
              wd_fire = 1'b1;
            end else begin
              idle_cnt_d = idle_cnt_q + 32'd1;
            end
            if (wd_fire) begin
              res_count_d = det_count;
              res_ok_d    = det_ok;
              res_ng_d    = det_ng;
              toerr_d     = 1'b1;
              state_d     = S_TOERR;
            end else if (state_q == S_ARM && det_count != 32'd0) begin
              state_d = S_RUN;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    det_rst_d = !(state_d == S_ARM || state_d == S_RUN);
    busy_d    = (state_d == S_CLEAR || state_d == S_ARM || state_d == S_RUN);
  end

  // State, outputs and counters; rst forces the detector into reset at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      det_rst_q   <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      toerr_q     <= 1'b0;
      res_count_q <= 32'd0;
      res_ok_q    <= 32'd0;
      res_ng_q    <= 32'd0;
      elapsed_q   <= 32'd0;
      tgt_q       <= 32'd0;
      clr_cnt_q   <= 8'd0;
      idle_cnt_q  <= 32'd0;
      cnt_prev_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      det_rst_q   <= det_rst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      toerr_q     <= toerr_d;
      res_count_q <= res_count_d;
      res_ok_q    <= res_ok_d;
      res_ng_q    <= res_ng_d;
      elapsed_q   <= elapsed_d;
      tgt_q       <= tgt_d;
      clr_cnt_q   <= clr_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      cnt_prev_q  <= det_count;
    end
  end

  assign det_rst     = det_rst_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = toerr_q;
  assign res_count   = res_count_q;
  assign res_ok      = res_ok_q;
  assign res_ng      = res_ng_q;
  assign elapsed     = elapsed_q;
  assign state       = state_q;

endmodule

// File: doc/rx_measure_ctrl.md
# rx_measure_ctrl

Run controller for the receive-side frame error measurement. It sequences one measurement run of the error detector: holds the detector in reset, releases it, waits for the detector to sync on the first aux==0 frame, then counts until a programmed frame target is reached or the link goes silent. It latches the final count, ok and ng totals plus elapsed cycles for the host/debug side. It sits between the host control registers and the detector in the rx path. All detector inputs come from the same clock domain.

## Interface
- CLR_CYCLES, 16: cycles det_rst is held high at run start; legal range is 1..255.
- TIMEOUT_CYCLES, 125000000: cycles without det_count change before the run aborts as timed out.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle run request.
- abort  in  1  single-cycle cancel request.
- target_frames  in  32  frame target; sampled on accepted start; 0 is treated as 1.
- det_count, det_ok, det_ng  in  32 each  live detector counters.
- det_rst  out  1  reset to the detector.
- busy  out  1  high in CLEAR, ARM and RUN.
- done  out  1  run finished normally; held until next accepted start.
- timeout_err  out  1  run ended by watchdog; held until next accepted start.
- res_count, res_ok, res_ng  out  32 each  latched results.
- elapsed  out  32  cycles spent in ARM+RUN; saturates at 0xFFFFFFFF.
- state  out  3  current state encoding, for debug.

## Operation
- States:
  - IDLE=0, CLEAR=1, ARM=2, RUN=3, DONE=4, TOERR=5.
  - Encodings 6 and 7 are illegal and go to IDLE on the next clock.
- Reset values:
  - state=IDLE, det_rst=1.
  - busy, done, timeout_err = 0.
  - res_*, elapsed, internal target and counters = 0.
- IDLE, DONE, TOERR:
  - det_rst=1.
  - start latches tgt = max(target_frames,1), clears done, timeout_err, res_* and elapsed, and goes to CLEAR.
- CLEAR:
  - det_rst=1 and clr_cnt counts up.
  - After CLR_CYCLES cycles in CLEAR, go to ARM with det_rst=0.
- ARM:
  - Wait for det_count != 0, meaning the detector has synced.
  - Then go to RUN.
- RUN:
  - When det_count >= tgt (unsigned 32-bit compare), latch res_* from the det_* inputs of that same cycle, set done, and go to DONE.
- Watchdog (ARM and RUN):
  - idle_cnt clears on entry to ARM and on any cycle where det_count differs from its registered copy; otherwise it increments.
  - When idle_cnt reaches TIMEOUT_CYCLES - 1, latch res_* from det_*, set timeout_err, and go to TOERR.
- elapsed increments every cycle in ARM and RUN and saturates at 0xFFFFFFFF.
- abort:
  - In CLEAR, ARM or RUN: go to IDLE, det_rst=1, res_* and elapsed keep their current values, done=timeout_err=0.
  - In any other state abort is ignored.
- Simultaneous events, highest priority first:
  1. abort
  2. completion (target reached)
  3. watchdog
  4. start
- start while busy is ignored. tgt does not change mid-run.
- Reset mid-run: all outputs return to reset values immediately (asynchronous); det_rst asserts without waiting for a clock.

## Timing
- start sampled at edge N:
  - state=CLEAR and det_rst=1 from N+1.
  - det_rst falls and state=ARM at N+1+CLR_CYCLES.
- ARM to RUN: one cycle after det_count first reads nonzero.
- Completion: if det_count>=tgt is seen at edge M, res_* holds the det_* values sampled at M, and done=1 from M+1.
- busy is a registered decode of state and matches state every cycle.
- Watchdog: with det_count frozen from ARM entry, TOERR is entered exactly TIMEOUT_CYCLES cycles after ARM entry.
- det_rst is registered and glitch-free; it is asserted asynchronously by rst.

## Test plan
- Reset then idle:
  - Stimulus: assert rst mid-RUN.
  - Required: det_rst=1, state=0, done=0 and res_*=0 with no clock edge; after release, state stays 0.
- Normal run:
  - Stimulus: CLR_CYCLES=4, target_frames=10; detector model increments count/ok each frame and starts counting 20 cycles after det_rst falls.
  - Required: det_rst high for exactly 4 cycles; ARM→RUN on the first nonzero count; done=1 with res_count=10, res_ok=10, res_ng=0.
- Target 0 and error frames:
  - Stimulus: target_frames=0; first frame counted as ng.
  - Required: run ends at det_count=1 with res_ng=1 and done=1.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=100, target_frames=50, detector stops at count=7.
  - Required: TOERR exactly 100 cycles after the last count change; timeout_err=1, done=0, res_count=7.
- Abort and start collisions:
  - abort in RUN → IDLE next cycle with det_rst=1.
  - start while busy → no effect, tgt unchanged.
  - abort and completion in the same cycle → IDLE with done=0.
- Restart after DONE:
  - Stimulus: second start.
  - Required: done clears at N+1, elapsed resets to 0, results overwritten by the second run.
